rand_arbiter: RTL and testbench

Shares one 13-bit Fibonacci LFSR between `NREQ` requesters. Requests are granted round-robin. For each grant the block advances the LFSR by a full 13 shifts, reduces the result modulo the requester's bound with a bit-serial restoring remainder, and returns the value with a one-cycle acknowledge. It is the single source of random numbers for game logic (spawn positions, delays), so no two consumers ever see correlated or partially-shifted values.

---
 rtl/rand_arbiter_pkg.sv | 31 +++
 rtl/rand_arbiter_lfsr13.sv | 26 ++
 rtl/rand_arbiter.sv | 168 ++++++++++++++++
 tb/tb_rand_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rand_arbiter_pkg.sv
// Shared definitions for the random-number arbiter: LFSR geometry, seed,
// feedback taps, FSM encoding and the step counter limits.
package rand_pkg;

  localparam int          LFSR_W    = 13;
  localparam logic [12:0] LFSR_SEED = 13'h000F;

  // Feedback taps of the 13-bit Fibonacci LFSR
  localparam int TAP_A = 12;
  localparam int TAP_B = 3;
  localparam int TAP_C = 2;
  localparam int TAP_D = 0;

  localparam int         CNT_W     = 4;
  localparam logic [3:0] LAST_STEP = 4'd12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One LFSR step: shift left, feedback enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] r);
    logic fb;
    fb = r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
    return {r[LFSR_W-2:0], fb};
  endfunction

endpackage

// File: rtl/rand_arbiter_lfsr13.sv
// 13-bit Fibonacci LFSR that only advances when told to.
module lfsr13
  import rand_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_r;

  // LFSR state: reseed on reset, advance only while step is high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_r <= LFSR_SEED;
    end else if (step) begin
      q_r <= lfsr_next(q_r);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out bounded random numbers from one shared
// LFSR. Each grant advances the LFSR by a full 13 steps, then reduces the
// value modulo the requester's bound with a bit-serial restoring remainder.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int BW   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*BW-1:0] bound,
  output logic [NREQ-1:0]    ack,
  output logic [LFSR_W-1:0]  rnd,
  output logic [2:0]         owner,
  output logic               busy
);

  state_t             state_r;
  state_t             state_s;
  logic [2:0]         ptr_r;
  logic [2:0]         owner_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [13:0]        bound_r;
  logic [LFSR_W-1:0]  div_r;
  logic [13:0]        rem_r;
  logic [NREQ-1:0]    ack_r;
  logic [LFSR_W-1:0]  rnd_r;
  logic               busy_r;

  logic               grant_found_s;
  logic [2:0]         grant_idx_s;
  logic [7:0]         req_ext_s;
  logic [BW-1:0]      sel_bound_s;
  logic [13:0]        rem_shift_s;
  logic [13:0]        rem_next_s;
  logic [LFSR_W-1:0]  lfsr_q_s;
  logic               lfsr_step_s;
  logic [NREQ-1:0]    one_s;

  assign req_ext_s   = 8'(req);
  assign lfsr_step_s = (state_r == SHIFT);
  assign one_s       = {{(NREQ-1){1'b0}}, 1'b1};

  lfsr13 u_lfsr (
    .clock (clock),
    .reset (reset),
    .step  (lfsr_step_s),
    .q     (lfsr_q_s)
  );

  // Round-robin pick: first active request at or after the pointer, wrapping
  always_comb begin
    logic [3:0] cand;
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    cand          = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_r} + 4'(i);
      cand = (cand >= 4'(NREQ)) ? (cand - 4'(NREQ)) : cand;
      if (!grant_found_s && req_ext_s[cand[2:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand[2:0];
      end else begin
        grant_found_s = grant_found_s;
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Bound of the requester about to be granted
  always_comb begin
    sel_bound_s = bound[grant_idx_s*BW +: BW];
  end

  // One restoring-remainder iteration. With a zero bound the compare always
  // passes and nothing is subtracted, so the raw dividend is rebuilt in rem.
  always_comb begin
    rem_shift_s = (rem_r << 1) | {13'd0, div_r[LFSR_W-1]};
    if (rem_shift_s >= bound_r) begin
      rem_next_s = rem_shift_s - bound_r;
    end else begin
      rem_next_s = rem_shift_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) state_s = SHIFT;
        else               state_s = IDLE;
      end
      SHIFT: begin
        if (cnt_r == LAST_STEP) state_s = REDUCE;
        else                    state_s = SHIFT;
      end
      REDUCE: begin
        if (cnt_r == LAST_STEP) state_s = DONE;
        else                    state_s = REDUCE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      owner_r <= 3'd0;
      cnt_r   <= {CNT_W{1'b0}};
      bound_r <= 14'd0;
      div_r   <= {LFSR_W{1'b0}};
      rem_r   <= 14'd0;
      ack_r   <= {NREQ{1'b0}};
      rnd_r   <= {LFSR_W{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      ack_r   <= {NREQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (grant_found_s) begin
            owner_r <= grant_idx_s;
            bound_r <= {{(14-BW){1'b0}}, sel_bound_s};
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        SHIFT: begin
          if (cnt_r == LAST_STEP) begin
            // The LFSR takes its 13th step on this same edge
            div_r <= lfsr_next(lfsr_q_s);
            rem_r <= 14'd0;
            cnt_r <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        REDUCE: begin
          rem_r <= rem_next_s;
          div_r <= {div_r[LFSR_W-2:0], 1'b0};
          cnt_r <= cnt_r + 4'd1;
          if (cnt_r == LAST_STEP) begin
            rnd_r <= rem_next_s[LFSR_W-1:0];
            ack_r <= one_s << owner_r;
          end
        end
        DONE: begin
          ptr_r <= (owner_r == 3'(NREQ-1)) ? 3'd0 : (owner_r + 3'd1);
        end
        default: begin
          ptr_r <= 3'd0;
        end
      endcase
    end
  end

  assign ack   = ack_r;
  assign rnd   = rnd_r;
  assign owner = owner_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_rand_arbiter.sv
// Self-checking bench for rand_arbiter: a golden LFSR model pushes expected
// results into a scoreboard at grant time; they are popped on each ack.
module tb_rand_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] bound;
  logic [3:0]  ack;
  logic [12:0] rnd;
  logic [2:0]  owner;
  logic        busy;

  logic [1:0]  req13;
  logic [25:0] bound13;
  logic [1:0]  ack13;
  logic [12:0] rnd13;
  logic [2:0]  owner13;
  logic        busy13;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          who;
    logic [12:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [12:0] model_lfsr;

  always #5 clock = ~clock;

  rand_arbiter #(.NREQ(4), .BW(8)) u_dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .bound (bound),
    .ack   (ack),
    .rnd   (rnd),
    .owner (owner),
    .busy  (busy)
  );

  rand_arbiter #(.NREQ(2), .BW(13)) u_dut13 (
    .clock (clock),
    .reset (reset),
    .req   (req13),
    .bound (bound13),
    .ack   (ack13),
    .rnd   (rnd13),
    .owner (owner13),
    .busy  (busy13)
  );

  function automatic logic [12:0] model_step(input logic [12:0] r);
    return {r[11:0], r[12] ^ r[3] ^ r[2] ^ r[0]};
  endfunction

  task automatic model_grant(input int who, input int bnd);
    exp_t e;
    for (int s = 0; s < 13; s++) model_lfsr = model_step(model_lfsr);
    e.who = who;
    e.val = (bnd == 0) ? model_lfsr : 13'(int'(model_lfsr) % bnd);
    sb.push_back(e);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = 4'd0;
    req13 = 2'd0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_lfsr = 13'h000F;
    sb.delete();
  endtask

  // Wait (bounded) for an ack; edges counts rising edges until it is seen
  task automatic wait_ack(input bit sel13, input int budget, output int edges, output bit seen);
    seen  = 1'b0;
    edges = 0;
    for (int e = 1; e <= budget && !seen; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (sel13 ? (ack13 != 2'd0) : (ack != 4'd0)) begin
        seen  = 1'b1;
        edges = e;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 4'd0; req13 = 2'd0; bound = 32'd0; bound13 = 26'd0;
    repeat (2) @(negedge clock);
    checks++; if (ack !== 4'd0)   begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (rnd !== 13'd0)  begin errors++; $display("FAIL reset_rnd got %h want 0", rnd); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    model_lfsr = 13'h000F;
    sb.delete();
  endtask

  task automatic test_single();
    exp_t e; int n; bit seen;
    apply_reset();
    bound = 32'd0; bound[7:0] = 8'd7;
    req = 4'b0001;
    model_grant(0, 7);
    @(posedge clock); @(negedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %b want 1", busy); end
    wait_ack(1'b0, 40, n, seen);
    checks++; if (!seen || n != 26) begin errors++; $display("FAIL single_latency got %0d want 26", n); end
    e = sb.pop_front();
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", ack); end
    checks++; if (rnd !== e.val)   begin errors++; $display("FAIL single_rnd_model got %0d want %0d", rnd, e.val); end
    checks++; if (rnd !== 13'd4)   begin errors++; $display("FAIL single_rnd got %0d want 4", rnd); end
    checks++; if (owner !== 3'(e.who)) begin errors++; $display("FAIL single_owner got %0d want %0d", owner, e.who); end
    req = 4'd0;
    @(posedge clock); @(negedge clock);
    checks++; if (ack !== 4'd0)  begin errors++; $display("FAIL ack_pulse got %b want 0000", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_fall got %b want 0", busy); end
    checks++; if (rnd !== 13'd4) begin errors++; $display("FAIL rnd_hold got %0d want 4", rnd); end
  endtask

  task automatic test_bound_zero();
    exp_t e; int n; bit seen;
    apply_reset();
    bound = 32'd0;
    req = 4'b0010;
    model_grant(1, 0);
    @(posedge clock); @(negedge clock);
    wait_ack(1'b0, 40, n, seen);
    e = sb.pop_front();
    checks++; if (!seen || n != 26) begin errors++; $display("FAIL raw_latency got %0d want 26", n); end
    checks++; if (ack !== 4'b0010)  begin errors++; $display("FAIL raw_ack got %b want 0010", ack); end
    checks++; if (rnd !== 13'h1FF4) begin errors++; $display("FAIL raw_rnd got %h want 1ff4", rnd); end
    checks++; if (rnd !== e.val)    begin errors++; $display("FAIL raw_rnd_model got %h want %h", rnd, e.val); end
    checks++; if (owner !== 3'd1)   begin errors++; $display("FAIL raw_owner got %0d want 1", owner); end
    req = 4'd0;
  endtask

  task automatic test_round_robin();
    exp_t e; int n; bit seen; logic [3:0] exp_ack;
    apply_reset();
    bound = {4{8'd100}};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) model_grant(k % 4, 100);
    @(posedge clock); @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      wait_ack(1'b0, 60, n, seen);
      e = sb.pop_front();
      exp_ack = 4'b0001 << e.who;
      checks++; if (!seen || n != ((k == 0) ? 26 : 28)) begin errors++; $display("FAIL rr_spacing[%0d] got %0d want %0d", k, n, (k == 0) ? 26 : 28); end
      checks++; if (owner !== 3'(e.who)) begin errors++; $display("FAIL rr_owner[%0d] got %0d want %0d", k, owner, e.who); end
      checks++; if (ack !== exp_ack)     begin errors++; $display("FAIL rr_ack[%0d] got %b want %b", k, ack, exp_ack); end
      checks++; if (rnd !== e.val)       begin errors++; $display("FAIL rr_rnd[%0d] got %0d want %0d", k, rnd, e.val); end
      checks++; if (rnd >= 13'd100)      begin errors++; $display("FAIL rr_range[%0d] got %0d want <100", k, rnd); end
    end
    req = 4'd0;
  endtask

  task automatic test_reset_mid();
    exp_t e; int n; bit seen;
    apply_reset();
    bound = 32'd0; bound[7:0] = 8'd7;
    req = 4'b0001;
    model_grant(0, 7);
    @(posedge clock); @(negedge clock);
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    req = 4'd0;
    sb.delete();
    model_lfsr = 13'h000F;
    #1;
    checks++; if (ack !== 4'd0)   begin errors++; $display("FAIL mid_ack got %b want 0000", ack); end
    checks++; if (rnd !== 13'd0)  begin errors++; $display("FAIL mid_rnd got %h want 0", rnd); end
    checks++; if (owner !== 3'd0) begin errors++; $display("FAIL mid_owner got %0d want 0", owner); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b1;
    wait_ack(1'b0, 40, n, seen);
    checks++; if (seen || busy !== 1'b0) begin errors++; $display("FAIL mid_dropped got ack %b busy %b want none", seen, busy); end
    bound = 32'd0;
    req = 4'b0001;
    model_grant(0, 0);
    @(posedge clock); @(negedge clock);
    wait_ack(1'b0, 40, n, seen);
    e = sb.pop_front();
    checks++; if (!seen || n != 26) begin errors++; $display("FAIL mid_latency got %0d want 26", n); end
    checks++; if (rnd !== 13'h1FF4) begin errors++; $display("FAIL mid_reseed got %h want 1ff4", rnd); end
    checks++; if (rnd !== e.val)    begin errors++; $display("FAIL mid_model got %h want %h", rnd, e.val); end
    req = 4'd0;
  endtask

  task automatic test_drop();
    exp_t e; int n; bit seen;
    apply_reset();
    bound = 32'd0; bound[7:0] = 8'd1; bound[15:8] = 8'd50;
    req = 4'b0001;
    model_grant(0, 1);
    @(posedge clock); @(negedge clock);
    repeat (5) @(negedge clock);
    req = 4'b0000;
    repeat (5) @(negedge clock);
    req = 4'b0010;
    model_grant(1, 50);
    wait_ack(1'b0, 40, n, seen);
    e = sb.pop_front();
    checks++; if (!seen || (10 + n) != 26) begin errors++; $display("FAIL drop_latency got %0d want 26", 10 + n); end
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL drop_ack got %b want 0001", ack); end
    checks++; if (rnd !== 13'd0 || rnd !== e.val) begin errors++; $display("FAIL drop_rnd got %0d want 0", rnd); end
    wait_ack(1'b0, 60, n, seen);
    e = sb.pop_front();
    checks++; if (!seen || n != 28)   begin errors++; $display("FAIL late_spacing got %0d want 28", n); end
    checks++; if (ack !== 4'b0010)    begin errors++; $display("FAIL late_ack got %b want 0010", ack); end
    checks++; if (owner !== 3'd1)     begin errors++; $display("FAIL late_owner got %0d want 1", owner); end
    checks++; if (rnd !== e.val)      begin errors++; $display("FAIL late_rnd got %0d want %0d", rnd, e.val); end
    req = 4'd0;
  endtask

  task automatic test_bounds();
    exp_t e; int n; bit seen;
    apply_reset();
    bound = 32'd0; bound[7:0] = 8'hFF; bound[15:8] = 8'd1;
    req = 4'b0001;
    model_grant(0, 255);
    @(posedge clock); @(negedge clock);
    req = 4'b0010;
    model_grant(1, 1);
    wait_ack(1'b0, 40, n, seen);
    e = sb.pop_front();
    checks++; if (!seen || rnd > 13'd254) begin errors++; $display("FAIL bff_range got %0d want <=254", rnd); end
    checks++; if (rnd !== e.val)          begin errors++; $display("FAIL bff_rnd got %0d want %0d", rnd, e.val); end
    wait_ack(1'b0, 60, n, seen);
    e = sb.pop_front();
    checks++; if (!seen || rnd !== 13'd0 || rnd !== e.val) begin errors++; $display("FAIL b1_rnd got %0d want 0", rnd); end
    req = 4'd0;

    apply_reset();
    bound13 = {13'd0, 13'h1FFF};
    req13 = 2'b01;
    model_grant(0, 8191);
    model_grant(0, 8191);
    @(posedge clock); @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      wait_ack(1'b1, 60, n, seen);
      e = sb.pop_front();
      checks++; if (!seen || n != ((k == 0) ? 26 : 28)) begin errors++; $display("FAIL w13_spacing[%0d] got %0d", k, n); end
      checks++; if (ack13 !== 2'b01)   begin errors++; $display("FAIL w13_ack[%0d] got %b want 01", k, ack13); end
      checks++; if (rnd13 >= 13'h1FFF) begin errors++; $display("FAIL w13_range[%0d] got %0d want <8191", k, rnd13); end
      checks++; if (rnd13 !== e.val)   begin errors++; $display("FAIL w13_rnd[%0d] got %0d want %0d", k, rnd13, e.val); end
    end
    req13 = 2'd0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_bound_zero();
    test_round_robin();
    test_reset_mid();
    test_drop();
    test_bounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
